// File: rtl/sram_controller.sv
// Pipeline-facing controller for a 16-bit SRAM: each 32-bit access is split into a low then a high half-word phase.
// Define SRAM_WAIT_STATE_EN to stretch each phase to two cycles for slower SRAM parts.
module sram_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_q;
    logic [16:0] word_q;
    logic [15:0] wdata_hi_q;
    logic        wr_q;
    logic [31:0] rdata_q;
    logic [17:0] sram_addr_q;
    logic        we_n_q;
    logic        oe_q;
    logic [15:0] dq_out_q;
    logic        req;
    logic        phase_end;
    logic        unused_addr_bits;

    assign req              = MEM_R_EN | MEM_W_EN;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

`ifdef SRAM_WAIT_STATE_EN
    logic wait_q;
    assign phase_end = wait_q;
`else
    assign phase_end = 1'b1;
`endif

    // A request seen in IDLE already stalls the pipeline in that same cycle.
    assign ready = (state_q == DONE) | ((state_q == IDLE) & ~req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            wr_q        <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            dq_out_q    <= '0;
`ifdef SRAM_WAIT_STATE_EN
            wait_q      <= 1'b0;
`endif
        end else begin
`ifdef SRAM_WAIT_STATE_EN
            if (state_q == LO || state_q == HI) begin
                wait_q <= ~wait_q;
            end else begin
                wait_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (req) begin
                        // Write wins over read when both enables are set.
                        state_q     <= LO;
                        word_q      <= address[18:2];
                        wdata_hi_q  <= writeData[31:16];
                        wr_q        <= MEM_W_EN;
                        sram_addr_q <= {address[18:2], 1'b0};
                        we_n_q      <= ~MEM_W_EN;
                        oe_q        <= MEM_W_EN;
                        dq_out_q    <= MEM_W_EN ? writeData[15:0] : '0;
                    end
                end
                LO: begin
                    if (phase_end) begin
                        state_q     <= HI;
                        sram_addr_q <= {word_q, 1'b1};
                        dq_out_q    <= wr_q ? wdata_hi_q : '0;
                        if (!wr_q) begin
                            rdata_q[15:0] <= SRAM_DQ_in;
                        end
                    end
                end
                HI: begin
                    if (phase_end) begin
                        state_q     <= DONE;
                        sram_addr_q <= '0;
                        we_n_q      <= 1'b1;
                        oe_q        <= 1'b0;
                        dq_out_q    <= '0;
                        if (!wr_q) begin
                            rdata_q[31:16] <= SRAM_DQ_in;
                        end
                    end
                end
                DONE: begin
                    // Unconditional return keeps a still-held request from retriggering here.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign readData    = rdata_q;
    assign SRAM_ADDR   = sram_addr_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_DQ_oe  = oe_q;
    assign SRAM_DQ_out = dq_out_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM model; adapts phase length to SRAM_WAIT_STATE_EN.
module tb_sram_controller;

`ifdef SRAM_WAIT_STATE_EN
    localparam int PH = 2;
`else
    localparam int PH = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:1023];
    logic        ovr_en = 1'b0;
    logic [15:0] ovr_val = '0;

    sram_controller dut (
        .clk         (clk),
        .reset       (reset),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .address     (address),
        .writeData   (writeData),
        .readData    (readData),
        .ready       (ready),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_DQ_out (SRAM_DQ_out),
        .SRAM_DQ_oe  (SRAM_DQ_oe),
        .SRAM_DQ_in  (SRAM_DQ_in)
    );

    always #5 clk = ~clk;

    assign SRAM_DQ_in = ovr_en ? ovr_val : mem[SRAM_ADDR[9:0]];

    always @(posedge clk) begin
        if (!SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= SRAM_DQ_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one access from IDLE and checks every cycle up to and including DONE.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [15:0] dlo,
                              input logic [15:0] dhi, input logic ovr, input logic hold);
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        MEM_R_EN  = r;
        MEM_W_EN  = w;
        address   = a;
        writeData = wd;
        ovr_en    = ovr;
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL idle_req_ready got %0b exp 0", ready); end
        tick();
        if (!hold) begin
            MEM_R_EN  = 1'b0;
            MEM_W_EN  = 1'b0;
            address   = 32'hFFFF_FFFC;
            writeData = 32'h5A5A_A5A5;
        end
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < PH; k++) begin
                ovr_val  = (p == 0) ? dlo : dhi;
                exp_addr = {a[18:2], p[0]};
                exp_dq   = w ? ((p == 0) ? wd[15:0] : wd[31:16]) : 16'h0000;
                #1;
                checks++;
                if (ready !== 1'b0) begin errors++; $display("FAIL ph%0d_%0d_ready got %0b exp 0", p, k, ready); end
                checks++;
                if (SRAM_ADDR !== exp_addr) begin errors++; $display("FAIL ph%0d_%0d_addr got %h exp %h", p, k, SRAM_ADDR, exp_addr); end
                checks++;
                if (SRAM_WE_N !== ~w) begin errors++; $display("FAIL ph%0d_%0d_we_n got %0b exp %0b", p, k, SRAM_WE_N, ~w); end
                checks++;
                if (SRAM_DQ_oe !== w) begin errors++; $display("FAIL ph%0d_%0d_oe got %0b exp %0b", p, k, SRAM_DQ_oe, w); end
                checks++;
                if (SRAM_DQ_out !== exp_dq) begin errors++; $display("FAIL ph%0d_%0d_dq_out got %h exp %h", p, k, SRAM_DQ_out, exp_dq); end
                tick();
            end
        end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL done_ready got %0b exp 1", ready); end
        checks++;
        if (SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin
            errors++; $display("FAIL done_bus got we_n=%0b oe=%0b exp we_n=1 oe=0", SRAM_WE_N, SRAM_DQ_oe);
        end
        checks++;
        if (SRAM_ADDR !== 18'h0 || SRAM_DQ_out !== 16'h0) begin
            errors++; $display("FAIL done_idle_vals got addr=%h dq=%h exp 0", SRAM_ADDR, SRAM_DQ_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", ready); end
        checks++;
        if (SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin
            errors++; $display("FAIL rst_bus got we_n=%0b oe=%0b exp we_n=1 oe=0", SRAM_WE_N, SRAM_DQ_oe);
        end
        checks++;
        if (SRAM_ADDR !== 18'h0 || SRAM_DQ_out !== 16'h0) begin
            errors++; $display("FAIL rst_addr_dq got addr=%h dq=%h exp 0", SRAM_ADDR, SRAM_DQ_out);
        end
        checks++;
        if (readData !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", readData); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_readback();
        run_access(1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL wr_idle_ready got %0b exp 1", ready); end
        run_access(1'b1, 1'b0, 32'h0000_0404, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (readData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL readback got %h exp deadbeef", readData); end
        tick();
    endtask

    task automatic test_read();
        run_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 16'h1234, 16'hABCD, 1'b1, 1'b1);
        checks++;
        if (readData !== 32'hABCD_1234) begin errors++; $display("FAIL read_data got %h exp abcd1234", readData); end
    endtask

    task automatic test_back_to_back();
        tick();
        checks++;
        if (ready !== 1'b0 || SRAM_ADDR !== 18'h0) begin
            errors++; $display("FAIL b2b_idle got ready=%0b addr=%h exp ready=0 addr=0", ready, SRAM_ADDR);
        end
        run_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 16'h1111, 16'h2222, 1'b1, 1'b0);
        checks++;
        if (readData !== 32'h2222_1111) begin errors++; $display("FAIL b2b_data got %h exp 22221111", readData); end
        tick();
    endtask

    task automatic test_rw_both();
        run_access(1'b1, 1'b1, 32'h0000_0010, 32'h0000_00FF, 16'hBAD0, 16'hBAD1, 1'b1, 1'b0);
        checks++;
        if (readData !== 32'h2222_1111) begin errors++; $display("FAIL rw_both_rdata got %h exp 22221111", readData); end
        tick();
    endtask

    task automatic test_wait_read();
        run_access(1'b1, 1'b0, 32'h0000_0800, 32'h0, 16'hC0DE, 16'hF00D, 1'b1, 1'b0);
        checks++;
        if (readData !== 32'hF00D_C0DE) begin errors++; $display("FAIL wait_read_data got %h exp f00dc0de", readData); end
        tick();
    endtask

    task automatic test_reset_mid();
        MEM_W_EN  = 1'b1;
        address   = 32'h0000_0404;
        writeData = 32'h1234_5678;
        tick();
        MEM_W_EN = 1'b0;
        for (int k = 0; k < PH; k++) tick();
        checks++;
        if (SRAM_WE_N !== 1'b0 || SRAM_ADDR !== 18'h00203) begin
            errors++; $display("FAIL mid_hi got we_n=%0b addr=%h exp we_n=0 addr=00203", SRAM_WE_N, SRAM_ADDR);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %0b exp 1", ready); end
        checks++;
        if (SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin
            errors++; $display("FAIL mid_rst_bus got we_n=%0b oe=%0b exp we_n=1 oe=0", SRAM_WE_N, SRAM_DQ_oe);
        end
        checks++;
        if (readData !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata got %h exp 0", readData); end
        reset = 1'b0;
        tick();
        checks++;
        if (SRAM_WE_N !== 1'b1 || SRAM_ADDR !== 18'h0 || ready !== 1'b1) begin
            errors++; $display("FAIL mid_no_second_half got we_n=%0b addr=%h ready=%0b exp 1 0 1", SRAM_WE_N, SRAM_ADDR, ready);
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_read();
        test_back_to_back();
        test_rw_both();
        test_wait_read();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
